avr_dmem_arbiter: RTL

Two-master arbiter for the single-port synchronous data RAM behind the AVR core. It shares the RAM between the CPU data port and an external master (debug/DMA loader) and stalls the CPU when the external master owns the slot. The CPU normally has priority; an anti-starvation counter hands the RAM to the external master for a bounded burst. It sits between `avr_cpu` (d_addr/data_write/data_in/data_out/stall) and the data memory, which has 1-cycle registered read latency.

---
 rtl/avr_dmem_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/avr_dmem_arbiter.sv
// Two-master arbiter for the AVR single-port data RAM: CPU has priority and an
// anti-starvation counter forces a bounded external burst after MAX_WAIT conflicts.
module avr_dmem_arbiter #(
  parameter int ADDR_W    = 11,
  parameter int MAX_WAIT  = 4,
  parameter int BURST_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_rvalid,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [15:0]       ext_addr,
  input  logic [7:0]        ext_wdata,
  output logic              ext_gnt,
  output logic [7:0]        ext_rdata,
  output logic              ext_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_di,
  input  logic [7:0]        mem_do
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int BW = $clog2(BURST_MAX + 1);

  typedef enum logic {CPU_OWN = 1'b0, EXT_OWN = 1'b1} owner_t;

  owner_t        owner;
  logic [WW-1:0] wait_cnt;
  logic [BW-1:0] burst_cnt;
  logic          cpu_gnt;
  logic          ext_gnt_i;
  logic          rd_cpu_q;
  logic          rd_ext_q;

  // Handshake: a request is held stable until granted; a grant (cpu: ~cpu_stall,
  // ext: ext_gnt) in a cycle means the access is performed at the closing edge.
  always_comb begin
    cpu_gnt   = 1'b0;
    ext_gnt_i = 1'b0;
    if (!RST) begin
      if (owner == CPU_OWN) begin
        cpu_gnt   = cpu_req;
        ext_gnt_i = ext_req & ~cpu_req;
      end else begin
        ext_gnt_i = ext_req;
      end
    end
  end

  always_comb begin
    mem_addr = cpu_addr[ADDR_W-1:0];
    mem_di   = cpu_wdata;
    mem_we   = cpu_gnt & cpu_we;
    if (ext_gnt_i) begin
      mem_addr = ext_addr[ADDR_W-1:0];
      mem_di   = ext_wdata;
      mem_we   = ext_we;
    end
  end

  assign cpu_stall  = cpu_req & ~cpu_gnt;
  assign ext_gnt    = ext_gnt_i;
  assign cpu_rvalid = rd_cpu_q;
  assign ext_rvalid = rd_ext_q;
  assign cpu_rdata  = mem_do;
  assign ext_rdata  = mem_do;

  // Upper address bits are deliberately dropped: the RAM aliases across them.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[15:ADDR_W], ext_addr[15:ADDR_W]};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      owner     <= CPU_OWN;
      wait_cnt  <= '0;
      burst_cnt <= '0;
      rd_cpu_q  <= 1'b0;
      rd_ext_q  <= 1'b0;
    end else begin
      rd_cpu_q <= cpu_gnt & ~cpu_we;
      rd_ext_q <= ext_gnt_i & ~ext_we;
      case (owner)
        CPU_OWN: begin
          if (cpu_req && ext_req) begin
            if (wait_cnt >= WW'(MAX_WAIT - 1)) begin
              owner     <= EXT_OWN;
              wait_cnt  <= '0;
              burst_cnt <= '0;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end else begin
            wait_cnt <= '0;
          end
        end
        EXT_OWN: begin
          if (ext_req && burst_cnt != BW'(BURST_MAX - 1)) begin
            burst_cnt <= burst_cnt + 1'b1;
          end else begin
            // Burst exhausted or the external master went idle.
            owner     <= CPU_OWN;
            wait_cnt  <= '0;
            burst_cnt <= '0;
          end
        end
        default: owner <= CPU_OWN;
      endcase
    end
  end

endmodule
